pu_fc_array: RTL and testbench

PU_FC_ARRAY -- requirements
Module: pu_fc_array

---
 rtl/pu_fc_array.sv | 179 +++++++++++++++++
 tb/tb_pu_fc_array.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pu_fc_array.sv
// rtl/pu_fc_array.sv - fully-connected MAC array with bias, requantisation and argmax
module pu_fc_array #(
  parameter int NUM_CH  = 10,
  parameter int DIN_W   = 8,
  parameter int W_W     = 8,
  parameter int ACC_W   = 32,
  parameter int BIAS_W  = 16,
  parameter int OUT_W   = 8,
  parameter int VEC_LEN = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        valid_i,
  input  logic [DIN_W-1:0]            din_i,
  input  logic [NUM_CH*W_W-1:0]       win_i,
  input  logic [NUM_CH*BIAS_W-1:0]    bias_i,
  input  logic [4:0]                  shift_i,
  output logic                        ready_o,
  output logic                        busy_o,
  output logic [NUM_CH*ACC_W-1:0]     acc_o,
  output logic [NUM_CH*OUT_W-1:0]     data_o,
  output logic [$clog2(NUM_CH)-1:0]   argmax_o,
  output logic                        valid_o
);
  localparam int ARG_W  = $clog2(NUM_CH);
  localparam int CNT_W  = $clog2(VEC_LEN + 1);
  localparam int PROD_W = DIN_W + W_W;
  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_BIAS, S_QUANT, S_ARGMAX, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [4:0]                shift_q, shift_d;
  logic                      drain_q, drain_d;
  logic                      s1_vld_q, s1_vld_d;
  logic signed [DIN_W-1:0]   s1_din_q, s1_din_d;
  logic [NUM_CH*W_W-1:0]     s1_win_q, s1_win_d;
  logic signed [ACC_W-1:0]   acc_q [NUM_CH];
  logic signed [ACC_W-1:0]   acc_d [NUM_CH];
  logic signed [OUT_W-1:0]   data_q [NUM_CH];
  logic signed [OUT_W-1:0]   data_d [NUM_CH];
  logic [ARG_W-1:0]          scan_q, scan_d;
  logic [ARG_W-1:0]          arg_q, arg_d;
  logic signed [OUT_W-1:0]   best_q, best_d;

  function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [DIN_W-1:0] a,
                                                       input logic signed [W_W-1:0] b);
    logic signed [PROD_W-1:0] p;
    p = a * b;
    return ACC_W'(p);
  endfunction

  // One guard bit above ACC_W keeps the rounding add from wrapping before the shift.
  function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                                      input logic [4:0] sh);
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    sum = (ACC_W+1)'(acc) + rnd;
    sum = sum >>> sh;
    if (sum > OUT_MAX) return OUT_MAX[OUT_W-1:0];
    if (sum < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    return sum[OUT_W-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    drain_d  = drain_q;
    scan_d   = scan_q;
    arg_d    = arg_q;
    best_d   = best_q;
    acc_d    = acc_q;
    data_d   = data_q;
    s1_vld_d = valid_i && (state_q == S_ACC);
    s1_din_d = din_i;
    s1_win_d = win_i;

    if (s1_vld_q) begin
      for (int i = 0; i < NUM_CH; i++)
        acc_d[i] = acc_q[i] + mac_term(s1_din_q, s1_win_q[i*W_W +: W_W]);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ACC;
          cnt_d   = '0;
          shift_d = shift_i;
          arg_d   = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i]  = '0;
            data_d[i] = '0;
          end
        end
      end
      S_ACC: begin
        if (valid_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_BIAS;
      end
      S_BIAS: begin
        for (int i = 0; i < NUM_CH; i++)
          acc_d[i] = acc_q[i] + ACC_W'($signed(bias_i[i*BIAS_W +: BIAS_W]));
        state_d = S_QUANT;
      end
      S_QUANT: begin
        for (int i = 0; i < NUM_CH; i++)
          data_d[i] = requant(acc_q[i], shift_q);
        scan_d  = '0;
        state_d = S_ARGMAX;
      end
      S_ARGMAX: begin
        // Strict compare keeps the earliest channel on ties.
        if (scan_q == '0 || data_q[scan_q] > best_q) begin
          best_d = data_q[scan_q];
          arg_d  = scan_q;
        end
        scan_d = scan_q + 1'b1;
        if (scan_q == ARG_W'(NUM_CH - 1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      drain_q  <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_din_q <= '0;
      s1_win_q <= '0;
      scan_q   <= '0;
      arg_q    <= '0;
      best_q   <= '0;
      acc_q    <= '{default: '0};
      data_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      drain_q  <= drain_d;
      s1_vld_q <= s1_vld_d;
      s1_din_q <= s1_din_d;
      s1_win_q <= s1_win_d;
      scan_q   <= scan_d;
      arg_q    <= arg_d;
      best_q   <= best_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign acc_o[g*ACC_W +: ACC_W]  = acc_q[g];
    assign data_o[g*OUT_W +: OUT_W] = data_q[g];
  end

  assign argmax_o = arg_q;
  assign ready_o  = (state_q == S_ACC);
  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = (state_q == S_DONE);
endmodule

// File: tb/tb_pu_fc_array.sv
// tb/tb_pu_fc_array.sv - directed bench for pu_fc_array with a behavioural result model
module tb_pu_fc_array;
  localparam int NC = 10, DW = 8, WW = 8, AW = 32, BW = 16, OW = 8, VL = 4, ARGW = 4;
  localparam int LAT = VL + 2 + 1 + 1 + NC + 1;

  logic               clk, rst_i, start_i, valid_i;
  logic [DW-1:0]      din_i;
  logic [NC*WW-1:0]   win_i;
  logic [NC*BW-1:0]   bias_i;
  logic [4:0]         shift_i;
  logic               ready_o, busy_o, valid_o;
  logic [NC*AW-1:0]   acc_o;
  logic [NC*OW-1:0]   data_o;
  logic [ARGW-1:0]    argmax_o;

  pu_fc_array #(.NUM_CH(NC), .DIN_W(DW), .W_W(WW), .ACC_W(AW), .BIAS_W(BW),
                .OUT_W(OW), .VEC_LEN(VL)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .din_i(din_i),
    .win_i(win_i), .bias_i(bias_i), .shift_i(shift_i), .ready_o(ready_o), .busy_o(busy_o),
    .acc_o(acc_o), .data_o(data_o), .argmax_o(argmax_o), .valid_o(valid_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int din_v [VL];
  int w_v [VL][NC];
  int bias_v [NC];
  int shift_v;
  int exp_acc [NC];
  int exp_data [NC];
  int exp_arg;
  int n_vec = 0, n_err = 0, n_pulses = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic longint dut_acc(input int i);
    return longint'($signed(acc_o[i*AW +: AW]));
  endfunction

  function automatic longint dut_data(input int i);
    return longint'($signed(data_o[i*OW +: OW]));
  endfunction

  // Dot product plus bias, 32-bit wrap, round-half-up shift, clamp, first maximum.
  task automatic model();
    longint s, t;
    for (int i = 0; i < NC; i++) begin
      s = bias_v[i];
      for (int k = 0; k < VL; k++) s += longint'(din_v[k]) * longint'(w_v[k][i]);
      exp_acc[i] = int'(s);
      t = longint'(exp_acc[i]);
      if (shift_v > 0) t += longint'(1) << (shift_v - 1);
      t = t >>> shift_v;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      exp_data[i] = int'(t);
    end
    exp_arg = 0;
    for (int i = 1; i < NC; i++) if (exp_data[i] > exp_data[exp_arg]) exp_arg = i;
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      n_pulses++;
      for (int i = 0; i < NC; i++) begin
        chk($sformatf("acc_o[%0d]", i), dut_acc(i), exp_acc[i]);
        chk($sformatf("data_o[%0d]", i), dut_data(i), exp_data[i]);
      end
      chk("argmax_o", argmax_o, exp_arg);
      chk("busy_at_valid", busy_o, 1);
    end
  end

  task automatic drive_sample(input int k);
    valid_i = 1'b1;
    din_i = DW'(din_v[k]);
    for (int i = 0; i < NC; i++) win_i[i*WW +: WW] = WW'(w_v[k][i]);
  endtask

  task automatic begin_vec();
    @(negedge clk);
    for (int i = 0; i < NC; i++) bias_i[i*BW +: BW] = BW'(bias_v[i]);
    shift_i = 5'(shift_v);
    start_i = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_vec(input bit gaps, input bit extra_start, input int exp_lat);
    int cyc, p0;
    model();
    p0 = n_pulses;
    begin_vec();
    cyc = 1;
    chk("ready_in_acc", ready_o, 1);
    chk("busy_in_acc", busy_o, 1);
    for (int k = 0; k < VL; k++) begin
      if (gaps) begin
        valid_i = 1'b0;
        din_i = 8'h5a;
        start_i = extra_start && (k == 2);
        @(negedge clk);
        cyc++;
        start_i = 1'b0;
      end
      drive_sample(k);
      @(negedge clk);
      cyc++;
    end
    valid_i = 1'b1;
    din_i = 8'h7f;
    win_i = {NC{8'h7f}};
    while (!valid_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("valid_seen", valid_o, 1);
    if (exp_lat >= 0) chk("latency", cyc, exp_lat);
    valid_i = 1'b0;
    @(negedge clk);
    chk("valid_one_cycle", valid_o, 0);
    chk("busy_after_done", busy_o, 0);
    chk("ready_after_done", ready_o, 0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NC; i++) chk($sformatf("hold_data[%0d]", i), dut_data(i), exp_data[i]);
    chk("hold_argmax", argmax_o, exp_arg);
    chk("pulse_count", n_pulses - p0, 1);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NC; i++) begin
      chk({tag, "_acc"}, dut_acc(i), 0);
      chk({tag, "_data"}, dut_data(i), 0);
    end
    chk({tag, "_argmax"}, argmax_o, 0);
    chk({tag, "_ready"}, ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
  endtask

  task automatic fill(input int din, input int w, input int b, input int sh);
    for (int k = 0; k < VL; k++) begin
      din_v[k] = din;
      for (int i = 0; i < NC; i++) w_v[k][i] = w;
    end
    for (int i = 0; i < NC; i++) bias_v[i] = b;
    shift_v = sh;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; din_i = '0;
    win_i = '0; bias_i = '0; shift_i = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_i = 1'b0;

    fill(1, 0, 0, 0);
    for (int k = 0; k < VL; k++) for (int i = 0; i < NC; i++) w_v[k][i] = i;
    run_vec(1'b0, 1'b0, LAT);
    for (int i = 0; i < NC; i++) begin
      chk("lit_ramp_acc", dut_acc(i), 4 * i);
      chk("lit_ramp_data", dut_data(i), 4 * i);
    end
    chk("lit_ramp_argmax", argmax_o, 9);

    fill(127, 127, 0, 0);
    run_vec(1'b0, 1'b0, LAT);
    chk("lit_pos_acc", dut_acc(0), 64516);
    chk("lit_pos_sat", dut_data(0), 127);

    fill(127, -127, 0, 0);
    run_vec(1'b0, 1'b0, LAT);
    chk("lit_neg_acc", dut_acc(5), -64516);
    chk("lit_neg_sat", dut_data(5), -128);

    fill(1, 0, 0, 1);
    din_v[0] = 2;
    for (int k = 0; k < VL; k++) begin
      w_v[k][0] = 1;
      w_v[k][1] = -1;
    end
    run_vec(1'b0, 1'b0, LAT);
    chk("lit_round_pos_acc", dut_acc(0), 5);
    chk("lit_round_pos", dut_data(0), 3);
    chk("lit_round_neg", dut_data(1), -2);

    fill(1, 1, 0, 0);
    for (int k = 0; k < VL; k++) begin
      w_v[k][3] = 5;
      w_v[k][7] = 5;
    end
    run_vec(1'b0, 1'b0, LAT);
    chk("lit_tie_argmax", argmax_o, 3);
    run_vec(1'b1, 1'b1, -1);
    chk("lit_tie_gaps_argmax", argmax_o, 3);
    chk("lit_tie_gaps_acc", dut_acc(7), 20);

    for (int k = 0; k < VL; k++) begin
      din_v[k] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < NC; i++) w_v[k][i] = int'($urandom_range(0, 255)) - 128;
    end
    for (int i = 0; i < NC; i++) bias_v[i] = int'($urandom_range(0, 65535)) - 32768;
    shift_v = 3;
    begin_vec();
    for (int k = 0; k < 2; k++) begin
      drive_sample(k);
      @(negedge clk);
    end
    valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    rst_i = 1'b0;
    @(negedge clk);
    check_zero("post_reset");
    run_vec(1'b0, 1'b0, LAT);
    run_vec(1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
